// File: rtl/wb_pkg.sv
// Shared widths, the architectural zero-register index and queue entry types
// for the register-file writeback queue.
package wb_pkg;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 5;
  localparam int XZR_IDX = 31;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-wins search of the occupied queue entries for one read-port index.
module wb_fwd_match #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int DROP_XZR = 1,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] entry_reg,
  input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
  input  logic [PTR_W-1:0]             rd_ptr,
  input  logic [CNT_W-1:0]             count,
  input  logic [ADDR_W-1:0]            lookup_reg,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data
);
  import wb_pkg::*;

  logic [PTR_W-1:0] idx_s;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = {DATA_W{1'b0}};
    idx_s    = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (entry_reg[idx_s] == lookup_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[idx_s];
      end else begin
        fwd_hit  = fwd_hit;
        fwd_data = fwd_data;
      end
    end
    if ((DROP_XZR != 0) && (lookup_reg == ADDR_W'(XZR_IDX))) begin
      fwd_hit  = 1'b0;
      fwd_data = {DATA_W{1'b0}};
    end else begin
      fwd_hit  = fwd_hit;
      fwd_data = fwd_data;
    end
  end
endmodule

// File: rtl/writeback_queue.sv
// Circular writeback queue in front of the register-file write port, with
// two read-port forwarding lookups over the pending entries.
module writeback_queue #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = wb_pkg::DATA_W,
  parameter int ADDR_W   = wb_pkg::ADDR_W,
  parameter int DROP_XZR = 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [ADDR_W-1:0]       IN_REG,
  input  logic [DATA_W-1:0]       IN_DATA,
  input  logic                    WB_STALL,
  output logic                    REG_WRITE_ENABLE,
  output logic [ADDR_W-1:0]       WRITE_REG,
  output logic [DATA_W-1:0]       WRITE_DATA,
  input  logic [ADDR_W-1:0]       LOOKUP_REG_A,
  input  logic [ADDR_W-1:0]       LOOKUP_REG_B,
  output logic                    FWD_HIT_A,
  output logic                    FWD_HIT_B,
  output logic [DATA_W-1:0]       FWD_DATA_A,
  output logic [DATA_W-1:0]       FWD_DATA_B,
  output logic [$clog2(DEPTH):0]  COUNT,
  output logic                    EMPTY
);
  import wb_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]             rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0]             count_r;
  logic [DEPTH-1:0][ADDR_W-1:0] reg_mem_r;
  logic [DEPTH-1:0][DATA_W-1:0] data_mem_r;
  occ_state_t                   occ_s;
  logic                         in_ready_s, empty_s, accept_s, drop_s, push_s, pop_s;

  // Occupancy class derived from the count
  always_comb begin
    occ_s = OCC_PARTIAL;
    if (count_r == {CNT_W{1'b0}}) begin
      occ_s = OCC_EMPTY;
    end else if (count_r == CNT_W'(DEPTH)) begin
      occ_s = OCC_FULL;
    end else begin
      occ_s = OCC_PARTIAL;
    end
  end

  // A full queue refuses input even while popping: no pass-through path
  assign in_ready_s = (occ_s != OCC_FULL);
  assign empty_s    = (occ_s == OCC_EMPTY);
  assign accept_s   = IN_VALID && in_ready_s;
  assign drop_s     = (DROP_XZR != 0) && (IN_REG == ADDR_W'(XZR_IDX));
  assign push_s     = accept_s && !drop_s;
  assign pop_s      = !empty_s && !WB_STALL;

  // Pointer and occupancy state; pointers wrap naturally at power-of-two depth
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage needs no reset; only occupied slots are ever observed
  always_ff @(posedge CLK) begin
    if (push_s) begin
      reg_mem_r[wr_ptr_r]  <= IN_REG;
      data_mem_r[wr_ptr_r] <= IN_DATA;
    end
  end

  // Head presentation, zeroed while empty
  always_comb begin
    WRITE_REG  = {ADDR_W{1'b0}};
    WRITE_DATA = {DATA_W{1'b0}};
    if (!empty_s) begin
      WRITE_REG  = reg_mem_r[rd_ptr_r];
      WRITE_DATA = data_mem_r[rd_ptr_r];
    end else begin
      WRITE_REG  = {ADDR_W{1'b0}};
      WRITE_DATA = {DATA_W{1'b0}};
    end
  end

  assign REG_WRITE_ENABLE = pop_s;
  assign IN_READY         = in_ready_s;
  assign COUNT            = count_r;
  assign EMPTY            = empty_s;

  wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_XZR(DROP_XZR)) u_fwd_a (
    .entry_reg  (reg_mem_r),
    .entry_data (data_mem_r),
    .rd_ptr     (rd_ptr_r),
    .count      (count_r),
    .lookup_reg (LOOKUP_REG_A),
    .fwd_hit    (FWD_HIT_A),
    .fwd_data   (FWD_DATA_A)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_XZR(DROP_XZR)) u_fwd_b (
    .entry_reg  (reg_mem_r),
    .entry_data (data_mem_r),
    .rd_ptr     (rd_ptr_r),
    .count      (count_r),
    .lookup_reg (LOOKUP_REG_B),
    .fwd_hit    (FWD_HIT_B),
    .fwd_data   (FWD_DATA_B)
  );
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (DEPTH=4, DATA_W=64, ADDR_W=5, DROP_XZR=1).
module tb_writeback_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, wb_stall, we;
  logic [4:0]  in_reg, wr_reg, lk_a, lk_b;
  logic [63:0] in_data, wr_data, fd_a, fd_b;
  logic        hit_a, hit_b, empty;
  logic [2:0]  count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  writeback_queue dut (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_REG(in_reg), .IN_DATA(in_data), .WB_STALL(wb_stall),
    .REG_WRITE_ENABLE(we), .WRITE_REG(wr_reg), .WRITE_DATA(wr_data),
    .LOOKUP_REG_A(lk_a), .LOOKUP_REG_B(lk_b),
    .FWD_HIT_A(hit_a), .FWD_HIT_B(hit_b), .FWD_DATA_A(fd_a), .FWD_DATA_B(fd_b),
    .COUNT(count), .EMPTY(empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stalled(input logic [4:0] r, input logic [63:0] d);
    in_valid = 1'b1; in_reg = r; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_reg = 5'd0; in_data = 64'd0;
    wb_stall = 1'b0; lk_a = 5'd0; lk_b = 5'd0;
    #2;
    total_cnt++; if (empty !== 1'b1) $display("FAIL rst_empty got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (we !== 1'b0) $display("FAIL rst_we got %b want 0", we); else pass_cnt++;
    total_cnt++; if (count !== 3'd0) $display("FAIL rst_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if ({wr_reg, wr_data} !== 69'd0) $display("FAIL rst_wr got %0d/%h want 0/0", wr_reg, wr_data); else pass_cnt++;
    total_cnt++; if ({hit_a, hit_b, fd_a, fd_b} !== 130'd0) $display("FAIL rst_fwd got %b%b %h %h want all 0", hit_a, hit_b, fd_a, fd_b); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    wb_stall = 1'b0; in_valid = 1'b1; in_reg = 5'd4; in_data = 64'h000A;
    #1;
    total_cnt++; if (in_ready !== 1'b1 || we !== 1'b0) $display("FAIL single_pre got ready=%b we=%b want 1/0", in_ready, we); else pass_cnt++;
    tick();
    in_valid = 1'b0;
    #1;
    total_cnt++; if (we !== 1'b1 || wr_reg !== 5'd4 || wr_data !== 64'h000A)
      $display("FAIL single_write got we=%b reg=%0d data=%h want 1/4/a", we, wr_reg, wr_data); else pass_cnt++;
    total_cnt++; if (count !== 3'd1) $display("FAIL single_count got %0d want 1", count); else pass_cnt++;
    tick();
    total_cnt++; if (empty !== 1'b1 || we !== 1'b0 || count !== 3'd0)
      $display("FAIL single_drain got empty=%b we=%b count=%0d want 1/0/0", empty, we, count); else pass_cnt++;
  endtask

  task automatic test_stall_full();
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push_stalled(5'(i), 64'h100 + 64'(i));
    #1;
    total_cnt++; if (count !== 3'd4 || in_ready !== 1'b0)
      $display("FAIL full_state got count=%0d ready=%b want 4/0", count, in_ready); else pass_cnt++;
    total_cnt++; if (we !== 1'b0 || wr_reg !== 5'd1)
      $display("FAIL stall_hold got we=%b reg=%0d want 0/1", we, wr_reg); else pass_cnt++;
    push_stalled(5'd9, 64'h999);
    total_cnt++; if (count !== 3'd4) $display("FAIL fifth_push got count=%0d want 4", count); else pass_cnt++;
    wb_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = (i == 1); in_reg = 5'd9; in_data = 64'h999;
      #1;
      if (i == 1) begin
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL no_passthru got ready=%b want 0", in_ready); else pass_cnt++;
      end
      total_cnt++; if (we !== 1'b1 || wr_reg !== 5'(i) || wr_data !== 64'h100 + 64'(i))
        $display("FAIL drain_%0d got we=%b reg=%0d data=%h want 1/%0d/%h", i, we, wr_reg, wr_data, i, 64'h100 + 64'(i)); else pass_cnt++;
      tick();
      in_valid = 1'b0;
    end
    total_cnt++; if (empty !== 1'b1 || we !== 1'b0)
      $display("FAIL full_drained got empty=%b we=%b want 1/0", empty, we); else pass_cnt++;
  endtask

  task automatic test_forward();
    wb_stall = 1'b1;
    push_stalled(5'd5, 64'h11);
    push_stalled(5'd5, 64'h22);
    push_stalled(5'd7, 64'h33);
    lk_a = 5'd5; lk_b = 5'd6;
    #1;
    total_cnt++; if (hit_a !== 1'b1 || fd_a !== 64'h22) $display("FAIL fwd_young got %b/%h want 1/22", hit_a, fd_a); else pass_cnt++;
    total_cnt++; if (hit_b !== 1'b0 || fd_b !== 64'h0) $display("FAIL fwd_miss got %b/%h want 0/0", hit_b, fd_b); else pass_cnt++;
    lk_b = 5'd7;
    #1;
    total_cnt++; if (hit_b !== 1'b1 || fd_b !== 64'h33) $display("FAIL fwd_b7 got %b/%h want 1/33", hit_b, fd_b); else pass_cnt++;
    wb_stall = 1'b0;
    tick();
    total_cnt++; if (hit_a !== 1'b1 || fd_a !== 64'h22) $display("FAIL fwd_after_pop1 got %b/%h want 1/22", hit_a, fd_a); else pass_cnt++;
    tick();
    total_cnt++; if (hit_a !== 1'b0 || fd_a !== 64'h0) $display("FAIL fwd_after_pop2 got %b/%h want 0/0", hit_a, fd_a); else pass_cnt++;
    tick();
    total_cnt++; if (hit_b !== 1'b0 || empty !== 1'b1) $display("FAIL fwd_stale got hit=%b empty=%b want 0/1", hit_b, empty); else pass_cnt++;
  endtask

  task automatic test_xzr();
    wb_stall = 1'b0; in_valid = 1'b1; in_reg = 5'd31; in_data = 64'hDEAD;
    lk_a = 5'd31;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL xzr_ready got %b want 1", in_ready); else pass_cnt++;
    tick();
    in_valid = 1'b0;
    #1;
    total_cnt++; if (count !== 3'd0 || we !== 1'b0 || empty !== 1'b1)
      $display("FAIL xzr_drop got count=%0d we=%b empty=%b want 0/0/1", count, we, empty); else pass_cnt++;
    total_cnt++; if (hit_a !== 1'b0) $display("FAIL xzr_lookup got %b want 0", hit_a); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    wb_stall = 1'b1;
    push_stalled(5'd10, 64'h200);
    push_stalled(5'd11, 64'h201);
    wb_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_reg = 5'(12 + i); in_data = 64'h202 + 64'(i);
      #1;
      total_cnt++; if (we !== 1'b1 || wr_reg !== 5'(10 + i) || wr_data !== 64'h200 + 64'(i) || count !== 3'd2)
        $display("FAIL b2b_%0d got we=%b reg=%0d data=%h count=%0d want 1/%0d/%h/2", i, we, wr_reg, wr_data, count, 10 + i, 64'h200 + 64'(i)); else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 8; i < 10; i++) begin
      #1;
      total_cnt++; if (we !== 1'b1 || wr_data !== 64'h200 + 64'(i))
        $display("FAIL b2b_tail_%0d got we=%b data=%h want 1/%h", i, we, wr_data, 64'h200 + 64'(i)); else pass_cnt++;
      tick();
    end
    total_cnt++; if (empty !== 1'b1) $display("FAIL b2b_empty got %b want 1", empty); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int strobes;
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) push_stalled(5'(20 + i), 64'h300 + 64'(i));
    wb_stall = 1'b0;
    #1;
    total_cnt++; if (count !== 3'd3 || we !== 1'b1) $display("FAIL mid_pre got count=%0d we=%b want 3/1", count, we); else pass_cnt++;
    #1; rst_n = 1'b0;
    #1;
    total_cnt++; if (we !== 1'b0 || count !== 3'd0 || empty !== 1'b1)
      $display("FAIL mid_reset got we=%b count=%0d empty=%b want 0/0/1", we, count, empty); else pass_cnt++;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (we === 1'b1) strobes++;
    end
    total_cnt++; if (strobes !== 0 || count !== 3'd0 || in_ready !== 1'b1)
      $display("FAIL mid_release got strobes=%0d count=%0d ready=%b want 0/0/1", strobes, count, in_ready); else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_stall_full();
    test_forward();
    test_xzr();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
